calculadora_seq: RTL
====================

CALCULADORA_SEQ -- requirements
Module: calculadora_seq

Interface
REQ-001 Parameter LARGURA, default 8: operand and result width in bits, minimum 2.
REQ-002 Parameter COM_MULT, default 1: 1 enables opcode 101 (multiply); 0 makes 101 invalid.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 inicio  input  1  operation request; accepted only in a cycle where pronto=1.
REQ-006 codigo  input  3  opcode, sampled on acceptance.
REQ-007 entrada_A  input  LARGURA  operand A, sampled on acceptance.
REQ-008 entrada_B  input  LARGURA  operand B, sampled on acceptance.
REQ-009 pronto  output  1  block idle and able to accept a request.
REQ-010 valido  output  1  one-cycle pulse marking that saida and the flags hold a new result.
REQ-011 saida  output  LARGURA  registered result; holds its value until the next result.
REQ-012 carry  output  1  carry-out (add), borrow (sub), or high half nonzero (multiply).
REQ-013 zero  output  1  saida==0 for the latest result.
REQ-014 erro  output  1  latest request had an invalid opcode.

Function
REQ-015 Opcodes: 000 clear; 001 pass A; 010 pass B; 011 A+B; 100 A-B; 101 A*B low LARGURA bits; 110 accumulate (saida+A); 111 invalid.
REQ-016 Single-cycle opcodes (000-100, 110, 111): request accepted at edge N; result, flags and valido=1 appear after edge N+1 (latency 1); pronto stays 1.
REQ-017 Multiply: acceptance moves the FSM OCIOSO->MULT and drops pronto; the FSM runs exactly LARGURA shift-add steps, then goes to FIM, where valido=1 for one cycle; FIM->OCIOSO with pronto=1. Acceptance-to-valido latency is LARGURA+1 cycles.
REQ-018 FSM states are exactly OCIOSO, MULT and FIM; no other encodings are reachable.
REQ-019 inicio while pronto=0 is ignored, with no queuing and no effect on the operation in progress.
REQ-020 Arithmetic is unsigned and modulo 2^LARGURA; carry = bit LARGURA of the (LARGURA+1)-bit sum; borrow = (A<B).
REQ-021 Accumulate (110) uses the current saida as its left operand; carry is set on wrap-around.
REQ-022 Clear (000) sets saida=0, carry=0, zero=1, erro=0.
REQ-023 Invalid opcode (111, or 101 when COM_MULT=0) sets saida=0, carry=0, zero=1, erro=1, and raises valido.
REQ-024 Flags change only together with valido; otherwise they hold.
REQ-025 Back-to-back single-cycle requests on consecutive cycles each produce one valido pulse, in order.

Reset
REQ-026 With rst_n=0, the FSM goes to OCIOSO immediately: saida=0, carry=0, zero=1, erro=0, valido=0, pronto=1.
REQ-027 Reset during MULT aborts the operation with no valido pulse; the first request after release is handled normally.
REQ-028 The block accepts requests from the first rising edge after rst_n deasserts.

Structure
REQ-029 Shared package calculadora_pkg holds the opcode constants (OP_ZERA, OP_A, OP_B, OP_SOMA, OP_SUB, OP_MULT, OP_ACC, OP_INV) and the FSM state type.
REQ-030 The shift-add datapath lives in one sub-module, multiplicador_serial (start/done, LARGURA-parameterised); all other logic stays in calculadora_seq.

Verification (LARGURA=8)
REQ-031 Reset release, then codigo=011, A=200, B=100 -> one cycle later saida=44, carry=1, zero=0, valido pulse of one cycle.
REQ-032 codigo=100, A=5, B=5 -> saida=0, zero=1, carry=0; then A=3, B=5 -> saida=254, carry=1.
REQ-033 codigo=101, A=13, B=11 -> pronto low for 8 cycles, valido 9 cycles after acceptance, saida=143, carry=0; a second inicio during MULT is ignored; A=16, B=16 -> saida=0, carry=1, zero=1.
REQ-034 Clear, then codigo=110 with A=100 on three consecutive cycles -> saida 100, 200, 44; carry set on the third; three valido pulses.
REQ-035 codigo=111 -> saida=0, erro=1, valido pulse; rst_n low mid-MULT -> outputs at reset values immediately, no valido pulse.

Source files
------------

// File: rtl/calculadora_pkg.sv
// calculadora_pkg: opcodes, FSM state type and opcode-validity helper
package calculadora_pkg;
    localparam logic [2:0] OP_ZERA = 3'b000;
    localparam logic [2:0] OP_A    = 3'b001;
    localparam logic [2:0] OP_B    = 3'b010;
    localparam logic [2:0] OP_SOMA = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_MULT = 3'b101;
    localparam logic [2:0] OP_ACC  = 3'b110;
    localparam logic [2:0] OP_INV  = 3'b111;

    typedef enum logic [1:0] {OCIOSO, MULT, FIM} estado_t;

    function automatic logic op_invalido(input logic [2:0] op, input logic com_mult);
        return op == OP_INV || (op == OP_MULT && !com_mult);
    endfunction
endpackage

// File: rtl/calculadora_if.sv
// calculadora_if: request/result bus of the sequential calculator
interface calculadora_if #(parameter int LARGURA = 8);
    logic               inicio;
    logic [2:0]         codigo;
    logic [LARGURA-1:0] entrada_A;
    logic [LARGURA-1:0] entrada_B;
    logic               pronto;
    logic               valido;
    logic [LARGURA-1:0] saida;
    logic               carry;
    logic               zero;
    logic               erro;

    modport master(output inicio, codigo, entrada_A, entrada_B,
                   input pronto, valido, saida, carry, zero, erro);
    modport slave(input inicio, codigo, entrada_A, entrada_B,
                  output pronto, valido, saida, carry, zero, erro);
endinterface

// File: rtl/multiplicador_serial.sv
// multiplicador_serial: unsigned shift-add multiplier, one partial product per cycle
module multiplicador_serial #(
    parameter int LARGURA = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [LARGURA-1:0]   a,
    input  logic [LARGURA-1:0]   b,
    output logic                 done,
    output logic [2*LARGURA-1:0] produto
);
    localparam int CW = $clog2(LARGURA + 1);

    logic [2*LARGURA-1:0] mcand;
    logic [LARGURA-1:0]   mplier;
    logic [CW-1:0]        cnt;

    // done is high during the cycle whose closing edge performs the final step
    assign done = cnt == CW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            produto <= '0;
        end else if (start) begin
            mcand   <= {{LARGURA{1'b0}}, a};
            mplier  <= b;
            cnt     <= CW'(LARGURA);
            produto <= '0;
        end else if (cnt != '0) begin
            produto <= mplier[0] ? produto + mcand : produto;
            mcand   <= mcand << 1;
            mplier  <= mplier >> 1;
            cnt     <= cnt - CW'(1);
        end
    end
endmodule

// File: rtl/calculadora_seq.sv
// calculadora_seq: sequential ALU; single-cycle ops pass through a one-stage request
// register, multiply runs the serial multiplier under the OCIOSO/MULT/FIM FSM
module calculadora_seq
    import calculadora_pkg::*;
#(
    parameter int LARGURA  = 8,
    parameter int COM_MULT = 1
) (
    input logic          clk,
    input logic          rst_n,
    calculadora_if.slave bus
);
    estado_t              estado;
    logic                 pend;
    logic [2:0]           pop;
    logic [LARGURA-1:0]   pa;
    logic [LARGURA-1:0]   pb;
    logic [LARGURA:0]     res;
    logic                 aceita;
    logic                 inicia_mult;
    logic                 mult_done;
    logic [2*LARGURA-1:0] produto;

    assign aceita      = bus.inicio && bus.pronto;
    assign inicia_mult = aceita && bus.codigo == OP_MULT && COM_MULT != 0;

    // bit LARGURA carries carry/borrow; clear, invalid and disabled multiply all yield 0
    always_comb begin
        res = pop == OP_A    ? {1'b0, pa} :
              pop == OP_B    ? {1'b0, pb} :
              pop == OP_SOMA ? {1'b0, pa} + {1'b0, pb} :
              pop == OP_SUB  ? {pa < pb, pa - pb} :
              pop == OP_ACC  ? {1'b0, bus.saida} + {1'b0, pa} : '0;
    end

    multiplicador_serial #(.LARGURA(LARGURA)) u_mult (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (inicia_mult),
        .a       (bus.entrada_A),
        .b       (bus.entrada_B),
        .done    (mult_done),
        .produto (produto)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado     <= OCIOSO;
            pend       <= 1'b0;
            pop        <= OP_ZERA;
            pa         <= '0;
            pb         <= '0;
            bus.pronto <= 1'b1;
            bus.valido <= 1'b0;
            bus.saida  <= '0;
            bus.carry  <= 1'b0;
            bus.zero   <= 1'b1;
            bus.erro   <= 1'b0;
        end else begin
            bus.valido <= pend;
            pend       <= aceita && !inicia_mult;
            if (aceita) begin
                pop <= bus.codigo;
                pa  <= bus.entrada_A;
                pb  <= bus.entrada_B;
            end
            if (pend) begin
                bus.saida <= res[LARGURA-1:0];
                bus.carry <= res[LARGURA];
                bus.zero  <= res[LARGURA-1:0] == '0;
                bus.erro  <= op_invalido(pop, COM_MULT != 0);
            end
            case (estado)
                OCIOSO: if (inicia_mult) begin
                    estado     <= MULT;
                    bus.pronto <= 1'b0;
                end
                MULT: if (mult_done) begin
                    estado     <= FIM;
                    bus.pronto <= 1'b1;
                end
                FIM: begin
                    bus.valido <= 1'b1;
                    bus.saida  <= produto[LARGURA-1:0];
                    bus.carry  <= |produto[2*LARGURA-1:LARGURA];
                    bus.zero   <= produto[LARGURA-1:0] == '0;
                    bus.erro   <= 1'b0;
                    estado     <= inicia_mult ? MULT : OCIOSO;
                    bus.pronto <= !inicia_mult;
                end
                default: estado <= OCIOSO;
            endcase
        end
    end
endmodule
